// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM write aligner: size encodings, lane-count helpers, FSM states.
package sram_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'd0,
      SZ_HALF  = 2'd1,
      SZ_WORD  = 2'd2,
      SZ_DWORD = 2'd3
   } size_e;

   // IDLE: out register empty; HOLD: single or last beat pending; SPLIT: first of two beats pending
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      SPLIT = 2'd2
   } state_e;

   function automatic int nb_of(input int data_w);
      return data_w / 8;
   endfunction

   // DATA_W must be at least 16 so the lane offset field is non-empty
   function automatic int off_w_of(input int data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/sram_write_aligner_rotate.sv
// Combinational lane rotator: places a right-justified 1..NB byte write onto SRAM byte lanes,
// returning the low-word beat, the spill-over beat for the next word, and a crossing flag.
module byte_lane_rotate
   import sram_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]           data,
   input  logic [off_w_of(DATA_W)-1:0] off,
   input  logic [1:0]                  size,
   output logic [DATA_W-1:0]           lo_data,
   output logic [nb_of(DATA_W)-1:0]    lo_mask,
   output logic [DATA_W-1:0]           hi_data,
   output logic [nb_of(DATA_W)-1:0]    hi_mask,
   output logic                        crossing
);

   localparam int NB    = nb_of(DATA_W);
   localparam int OFF_W = off_w_of(DATA_W);

   logic [1:0]          n_log;
   int                  nbytes;
   logic [NB-1:0]       byte_en;
   logic [DATA_W-1:0]   data_m;
   logic [2*DATA_W-1:0] wide_data;
   logic [2*NB-1:0]     wide_mask;

   // A double-width shift puts the spill-over bytes directly into the upper word
   always_comb begin
      n_log   = (32'(size) > 32'(OFF_W)) ? 2'(OFF_W) : size;
      nbytes  = 32'd1 << n_log;
      byte_en = '0;
      data_m  = '0;
      for (int i = 0; i < NB; i++) begin
         byte_en[i]       = (i < nbytes);
         data_m[8*i +: 8] = byte_en[i] ? data[8*i +: 8] : 8'h00;
      end
      wide_data = {{DATA_W{1'b0}}, data_m} << {off, 3'b000};
      wide_mask = {{NB{1'b0}}, byte_en} << off;
   end

   assign lo_data  = wide_data[DATA_W-1:0];
   assign hi_data  = wide_data[2*DATA_W-1:DATA_W];
   assign lo_mask  = wide_mask[NB-1:0];
   assign hi_mask  = wide_mask[2*NB-1:NB];
   assign crossing = |hi_mask;

endmodule

// File: rtl/sram_write_aligner.sv
// Registered write-data aligner in front of an SRAM macro: 1-cycle latency, one beat per cycle
// for non-crossing writes, word-crossing writes take two beats and stall the input for one.
module sram_write_aligner
   import sram_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [ADDR_W+off_w_of(DATA_W)-1:0]   in_addr,
   input  logic [1:0]                           in_size,
   input  logic [DATA_W-1:0]                    in_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [ADDR_W-1:0]                    out_addr,
   output logic [DATA_W-1:0]                    out_data,
   output logic [nb_of(DATA_W)-1:0]             out_wmask
);

   localparam int NB    = nb_of(DATA_W);
   localparam int OFF_W = off_w_of(DATA_W);

   state_e            state, state_nxt;
   logic              accept, load_new, load_b2;

   logic [DATA_W-1:0] lo_data, hi_data;
   logic [NB-1:0]     lo_mask, hi_mask;
   logic              crossing;

   logic [ADDR_W-1:0] in_word;
   logic [ADDR_W-1:0] b2_addr;
   logic [DATA_W-1:0] b2_data;
   logic [NB-1:0]     b2_mask;

   assign in_word   = in_addr[ADDR_W+OFF_W-1:OFF_W];
   assign out_valid = (state != IDLE);
   assign in_ready  = !out_valid | (out_ready & (state != SPLIT));
   assign accept    = in_valid & in_ready;

   byte_lane_rotate #(.DATA_W(DATA_W)) u_rotate (
      .data     (in_data),
      .off      (in_addr[OFF_W-1:0]),
      .size     (in_size),
      .lo_data  (lo_data),
      .lo_mask  (lo_mask),
      .hi_data  (hi_data),
      .hi_mask  (hi_mask),
      .crossing (crossing)
   );

   always_comb begin
      state_nxt = state;
      load_new  = 1'b0;
      load_b2   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               load_new  = 1'b1;
               state_nxt = crossing ? SPLIT : HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               if (accept) begin
                  load_new  = 1'b1;
                  state_nxt = crossing ? SPLIT : HOLD;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         SPLIT: begin
            if (out_ready) begin
               load_b2   = 1'b1;
               state_nxt = HOLD;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_addr  <= '0;
         out_data  <= '0;
         out_wmask <= '0;
         b2_addr   <= '0;
         b2_data   <= '0;
         b2_mask   <= '0;
      end else begin
         state <= state_nxt;
         if (load_new) begin
            out_addr  <= in_word;
            out_data  <= lo_data;
            out_wmask <= lo_mask;
            // Natural ADDR_W-bit wrap sends the spill-over beat of the top word to word 0
            b2_addr   <= in_word + 1'b1;
            b2_data   <= hi_data;
            b2_mask   <= hi_mask;
         end else if (load_b2) begin
            out_addr  <= b2_addr;
            out_data  <= b2_data;
            out_wmask <= b2_mask;
         end
      end
   end

endmodule

// File: tb/tb_sram_write_aligner.sv
// Randomized and directed bench for sram_write_aligner (DATA_W=32, ADDR_W=9) against a beat-queue model.
module tb_sram_write_aligner;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [10:0] in_addr;
   logic [1:0]  in_size;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [8:0]  out_addr;
   logic [31:0] out_data;
   logic [3:0]  out_wmask;

   sram_write_aligner #(.DATA_W(32), .ADDR_W(9)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_addr   (in_addr),
      .in_size   (in_size),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_data  (out_data),
      .out_wmask (out_wmask)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [8:0]  addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } beat_t;

   beat_t q[$];
   int    n_checks = 0;
   int    n_pass   = 0;
   bit    chk_en   = 1'b0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
   endfunction

   // Model: a write is a list of SRAM beats computed from byte arithmetic
   function automatic void push_write(input logic [10:0] a, input logic [1:0] s, input logic [31:0] d);
      int n    = 1 << ((s > 2'd2) ? 2 : int'(s));
      int off  = int'(a % 4);
      int word = int'(a / 4);
      longint unsigned val = 64'(d) & ((64'd1 << (8 * n)) - 64'd1);
      beat_t b;
      b.addr = 9'(word);
      b.data = 32'(val << (8 * off));
      b.mask = 4'(((1 << n) - 1) << off);
      q.push_back(b);
      if (off + n > 4) begin
         b.addr = 9'((word + 1) % 512);
         b.data = 32'(val >> (8 * (4 - off)));
         b.mask = 4'((1 << (off + n - 4)) - 1);
         q.push_back(b);
      end
   endfunction

   always @(posedge clk) begin
      bit rdy;
      if (rst) begin
         q.delete();
      end else begin
         rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
         if (q.size() > 0 && out_ready) void'(q.pop_front());
         if (in_valid && rdy) push_write(in_addr, in_size, in_data);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         #2;
         check("in_ready", 64'(in_ready),
               64'((q.size() == 0) || (q.size() == 1 && out_ready)));
         check("out_valid", 64'(out_valid), 64'(q.size() > 0));
         if (q.size() > 0) begin
            check("out_addr", 64'(out_addr), 64'(q[0].addr));
            check("out_data", 64'(out_data), 64'(q[0].data));
            check("out_wmask", 64'(out_wmask), 64'(q[0].mask));
         end
      end
   end

   task automatic drive(input logic v, input logic [10:0] a, input logic [1:0] s, input logic [31:0] d);
      in_valid = v;
      in_addr  = a;
      in_size  = s;
      in_data  = d;
   endtask

   task automatic beat_lit(input string tag, input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
      check({tag, "_vld"}, 64'(out_valid), 64'd1);
      check({tag, "_addr"}, 64'(out_addr), 64'(a));
      check({tag, "_data"}, 64'(out_data), 64'(d));
      check({tag, "_mask"}, 64'(out_wmask), 64'(m));
   endtask

   initial begin
      rst       = 1'b1;
      out_ready = 1'b1;
      drive(1'b0, '0, '0, '0);
      repeat (3) @(negedge clk);
      rst    = 1'b0;
      chk_en = 1'b1;
      #3;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_addr", 64'(out_addr), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_wmask", 64'(out_wmask), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // Byte at 0x006
      @(negedge clk); drive(1'b1, 11'h006, 2'd0, 32'h000000AB);
      @(negedge clk); in_valid = 1'b0;
      #3 beat_lit("byte", 9'd1, 32'h00AB0000, 4'b0100);
      @(negedge clk);

      // Half at 0x003 crosses into word 1
      @(negedge clk); out_ready = 1'b0; drive(1'b1, 11'h003, 2'd1, 32'h0000BEEF);
      @(negedge clk); in_valid = 1'b0;
      #3 beat_lit("half_b1", 9'd0, 32'hEF000000, 4'b1000);
      check("half_in_ready_stall", 64'(in_ready), 64'd0);
      @(negedge clk); out_ready = 1'b1;
      #3 check("half_in_ready_split", 64'(in_ready), 64'd0);
      @(negedge clk);
      #3 beat_lit("half_b2", 9'd1, 32'h000000BE, 4'b0001);
      @(negedge clk);

      // Back-to-back aligned words
      for (int i = 0; i <= 8; i++) begin
         @(negedge clk);
         if (i < 8) drive(1'b1, 11'(4 * i), 2'd2, 32'hA0000000 | 32'(i));
         else in_valid = 1'b0;
         #3;
         if (i > 0) beat_lit("b2b", 9'(i - 1), 32'hA0000000 | 32'(i - 1), 4'b1111);
      end
      @(negedge clk);

      // Stall with a beat pending and a new request waiting
      @(negedge clk); drive(1'b1, 11'h010, 2'd2, 32'hCAFEF00D);
      @(negedge clk); out_ready = 1'b0; drive(1'b1, 11'h014, 2'd2, 32'h12345678);
      for (int k = 0; k < 3; k++) begin
         #3;
         beat_lit("stall", 9'd4, 32'hCAFEF00D, 4'b1111);
         check("stall_in_ready", 64'(in_ready), 64'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk); in_valid = 1'b0;
      #3 beat_lit("resume", 9'd5, 32'h12345678, 4'b1111);
      @(negedge clk);

      // Word crossing the top of the address space
      @(negedge clk); drive(1'b1, 11'h7FE, 2'd2, 32'h11223344);
      @(negedge clk); in_valid = 1'b0;
      #3 beat_lit("wrap_b1", 9'd511, 32'h33440000, 4'b1100);
      @(negedge clk);
      #3 beat_lit("wrap_b2", 9'd0, 32'h00001122, 4'b0011);
      @(negedge clk);

      // Reset while a split is pending
      @(negedge clk); out_ready = 1'b0; drive(1'b1, 11'h003, 2'd1, 32'h0000BEEF);
      @(negedge clk); in_valid = 1'b0; rst = 1'b1;
      @(negedge clk); rst = 1'b0; out_ready = 1'b1;
      #3;
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_out_wmask", 64'(out_wmask), 64'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #3 check("mid_rst_no_b2", 64'(out_valid), 64'd0);
      end

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst       = ($urandom_range(0, 199) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         drive(($urandom_range(0, 9) < 7),
               ($urandom_range(0, 7) == 0) ? (11'h7FC | 11'($urandom_range(0, 3))) : 11'($urandom),
               2'($urandom_range(0, 3)),
               $urandom);
      end
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) @(negedge clk);
      #4;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
